// File: rtl/gray_frame_ctrl.sv
// gray_frame_ctrl: frame-synchronous config shadowing/commit plus frame
// pixel/line monitoring for the RGB-to-grayscale pipeline.
module gray_frame_ctrl #(
  parameter int unsigned H_ACT    = 1920,
  parameter int unsigned V_ACT    = 1080,
  parameter int unsigned PIX_W    = 22,
  parameter int unsigned LINE_W   = 12,
  parameter logic [1:0]  MODE_DEF = 2'd0,
  parameter logic [9:0]  C0_DEF   = 10'd306,
  parameter logic [9:0]  C1_DEF   = 10'd601,
  parameter logic [9:0]  C2_DEF   = 10'd117
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              valid_i,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [9:0]        cfg_wdata,
  output logic [1:0]        act_mode,
  output logic [9:0]        act_c0,
  output logic [9:0]        act_c1,
  output logic [9:0]        act_c2,
  output logic              in_frame,
  output logic              frame_done,
  output logic              frame_err,
  output logic              cfg_err,
  output logic [PIX_W-1:0]  pix_cnt_last,
  output logic [LINE_W-1:0] line_cnt_last,
  output logic [15:0]       frame_cnt
);

  typedef enum logic {WAIT_VS, IN_FRAME} state_t;

  state_t            state_q, state_d;
  logic              vs_d, hs_d;
  logic              vs_rise, hs_rise;
  logic [PIX_W-1:0]  pix_cnt, pix_nxt;
  logic [LINE_W-1:0] line_cnt, line_nxt;
  logic              close, bad_frame;
  logic [1:0]        sh_mode;
  logic [9:0]        sh_c0, sh_c1, sh_c2;
  logic              pending;
  logic [11:0]       coef_sum;
  logic              cfg_legal;
  logic              wr_clear, wr_arm;

  assign vs_rise   = vs_in & ~vs_d;
  assign hs_rise   = hs_in & ~hs_d;
  assign in_frame  = (state_q == IN_FRAME);
  assign coef_sum  = 12'(sh_c0) + 12'(sh_c1) + 12'(sh_c2);
  assign cfg_legal = (sh_mode != 2'd3) && (coef_sum <= 12'd1024);
  assign wr_clear  = cfg_we && (cfg_addr == 2'd3) && cfg_wdata[0];
  assign wr_arm    = cfg_we && !wr_clear;

  // Next state, saturating counter increments and frame-close detection.
  always_comb begin
    state_d = state_q;
    close   = 1'b0;
    pix_nxt = pix_cnt;
    if (valid_i && (pix_cnt != '1)) pix_nxt = pix_cnt + PIX_W'(1);
    line_nxt = line_cnt;
    if (hs_rise && (line_cnt != '1)) line_nxt = line_cnt + LINE_W'(1);
    case (state_q)
      WAIT_VS:  if (vs_rise) state_d = IN_FRAME;
      IN_FRAME: close = vs_rise;
      default:  state_d = WAIT_VS;
    endcase
    bad_frame = (pix_nxt != PIX_W'(H_ACT * V_ACT)) || (line_nxt != LINE_W'(V_ACT));
  end

  // State register and sync-edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_VS;
      vs_d    <= 1'b0;
      hs_d    <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_d    <= vs_in;
      hs_d    <= hs_in;
    end
  end

  // Frame counters, closing snapshot and result pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt       <= '0;
      line_cnt      <= '0;
      pix_cnt_last  <= '0;
      line_cnt_last <= '0;
      frame_cnt     <= '0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      frame_done <= close;
      frame_err  <= close && bad_frame;
      if (close) begin
        pix_cnt_last  <= pix_nxt;
        line_cnt_last <= line_nxt;
        frame_cnt     <= frame_cnt + 16'd1;
      end
      if (vs_rise) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else if (state_q == IN_FRAME) begin
        pix_cnt  <= pix_nxt;
        line_cnt <= line_nxt;
      end
    end
  end

  // Shadow register writes, pending tracking and commit at frame start.
  // The commit reads the shadows/pending as they were before this cycle's
  // write, so a write coinciding with vs_rise arms the following frame; the
  // rejection assignment to cfg_err comes last so it wins over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_mode  <= MODE_DEF;
      sh_c0    <= C0_DEF;
      sh_c1    <= C1_DEF;
      sh_c2    <= C2_DEF;
      act_mode <= MODE_DEF;
      act_c0   <= C0_DEF;
      act_c1   <= C1_DEF;
      act_c2   <= C2_DEF;
      pending  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      if (vs_rise) pending <= 1'b0;
      if (wr_arm) pending <= 1'b1;
      if (wr_clear) cfg_err <= 1'b0;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: sh_mode <= cfg_wdata[1:0];
          2'd1: sh_c0   <= cfg_wdata;
          2'd2: sh_c1   <= cfg_wdata;
          default: if (!cfg_wdata[0]) sh_c2 <= {1'b0, cfg_wdata[9:1]};
        endcase
      end
      if (vs_rise && pending) begin
        if (cfg_legal) begin
          act_mode <= sh_mode;
          act_c0   <= sh_c0;
          act_c1   <= sh_c1;
          act_c2   <= sh_c2;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/gray_frame_ctrl.md
Name: gray_frame_ctrl

Overview:
- Frame-synchronous configuration and monitoring controller for the RGB-to-grayscale pipeline.
- Holds shadow copies of the conversion mode and the weighted-sum coefficients, written over a simple register port.
- Commits a legal shadow set to the active outputs only at a frame start, so a frame is never converted with mixed settings.
- Counts pixels, lines and frames on the pipeline input stream and flags malformed frames.

Parameters:
- H_ACT, 1920, expected valid pixels per line.
- V_ACT, 1080, expected lines per frame.
- PIX_W, 22, width of the pixel counter; must hold H_ACT*V_ACT.
- LINE_W, 12, width of the line counter.
- MODE_DEF, 2'd0, reset mode: 0 weighted, 1 average, 2 bypass.
- C0_DEF / C1_DEF / C2_DEF, 10'd306 / 10'd601 / 10'd117, reset coefficients (x/1024).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- vs_in  in  1  vertical sync, active high; a rising edge marks frame start.
- hs_in  in  1  horizontal sync, active high; a rising edge marks line start.
- valid_i  in  1  input pixel valid, the same signal that drives the converter.
- cfg_we  in  1  register write strobe, single cycle.
- cfg_addr  in  2  0 = mode, 1 = C0, 2 = C1, 3 = control.
- cfg_wdata  in  10  write data.
- act_mode  out  2  committed mode.
- act_c0 / act_c1 / act_c2  out  10 each  committed coefficients.
- in_frame  out  1  high once the first frame start after reset has been seen.
- frame_done  out  1  one-cycle pulse when a complete frame closes.
- frame_err  out  1  one-cycle pulse, coincident with frame_done, when the closed frame was malformed.
- cfg_err  out  1  sticky flag: a commit was rejected.
- pix_cnt_last  out  PIX_W  pixel count of the last closed frame.
- line_cnt_last  out  LINE_W  line count of the last closed frame.
- frame_cnt  out  16  closed-frame counter, wraps.

Behaviour:
- Single clock domain; every register is reset synchronously.
- Reset values: act_* and shadows = defaults; all counters, *_last, frame_cnt, flags and pulses = 0; FSM = WAIT_VS.
- Edge detection:
  - vs_d and hs_d are registered copies of the sync inputs.
  - vs_rise = vs_in & ~vs_d; hs_rise = hs_in & ~hs_d; both are evaluated in the current cycle.
- Register writes:
  - addr 0 sets shadow mode from cfg_wdata[1:0].
  - addr 1 sets shadow C0; addr 2 sets shadow C1.
  - addr 3, bit0 = 1 clears cfg_err; bits[9:1] are written into shadow C2 only when bit0 = 0.
  - Every write sets the pending flag, except a pure clear (bit0 = 1).
- Commit, on the clock edge ending a vs_rise cycle while pending = 1:
  - Legal when shadow mode != 3 and C0 + C1 + C2 <= 1024; the sum is computed at 12 bits.
  - Legal: all shadows are copied to act_* and pending is cleared.
  - Illegal: act_* hold, cfg_err is set, and pending is cleared.
  - act_* change in the first cycle of the new frame and are stable for the whole frame.
- Simultaneous events:
  - A cfg_we in a vs_rise cycle updates its shadow but is excluded from that commit; it sets pending for the next frame.
  - A clear and a rejection in the same cycle: the rejection wins, so cfg_err = 1.
- FSM WAIT_VS:
  - Counters are idle.
  - On vs_rise: go to IN_FRAME, set in_frame, clear the counters, perform the commit.
  - No frame_done pulse is generated on this transition.
- FSM IN_FRAME:
  - pix_cnt += valid_i; line_cnt += hs_rise. Both saturate at all-ones.
  - On vs_rise:
    - pix_cnt_last and line_cnt_last take the final counts, including the current-cycle increment.
    - frame_done = 1 for the following cycle and frame_cnt increments.
    - frame_err = 1 when pix_cnt_last != H_ACT*V_ACT or line_cnt_last != V_ACT.
    - The counters then restart at 0.
  - valid_i and hs_rise in the vs_rise cycle count toward the closing frame.
  - Commit is evaluated in the same edge.
- Latency: frame_done and frame_err follow the vs_rise cycle by 1 clk; act_* update on the same edge.
- Reset asserted mid-frame: everything returns to reset values and the FSM returns to WAIT_VS; the partial frame is discarded with no pulse.

Test Plan:
- Reset, then check outputs: act_mode=0, act_c0=306, act_c1=601, act_c2=117, in_frame=0, cfg_err=0.
- Write mode=1 mid-frame (H_ACT=4, V_ACT=2 in the bench):
  - act_mode stays 0 until the next vs_rise.
  - act_mode becomes 1 on the following edge.
  - frame_done pulses with pix_cnt_last=8, line_cnt_last=2, frame_err=0.
- Write C0=600 (sum 1318), then vs_rise: act_c0 stays 306 and cfg_err=1. Write addr3=1: cfg_err returns to 0.
- Frame with 7 valid pixels and 2 lines, then vs_rise: frame_done=1, frame_err=1, pix_cnt_last=7, frame_cnt increments.
- cfg_we for mode=2 in the same cycle as vs_rise: not committed now; committed at the next vs_rise (act_mode=2).
- Assert reset at pixel 5 of a frame: no frame_done. The first vs_rise after reset gives in_frame=1 and no pulse; the second gives a pulse with correct counts.
